mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_if.sv | 32 +++
 rtl/mc_aludec.sv | 31 +++
 rtl/mc_controller.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: state, ALU, mux-select, opcode and funct encodings for the multicycle controller.
// Latency/backpressure: none; constants only. MC_BNE_EN adds the BNEEX state code.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ORIEX   = 4'd10,
      IWB     = 4'd11,
      JEX     = 4'd12
`ifdef MC_BNE_EN
      , BNEEX = 4'd13
`endif
   } state_t;

   // NONE yields alucontrol 000 in states that do not use the ALU
   typedef enum logic [2:0] {
      ALUOP_NONE  = 3'd0,
      ALUOP_ADD   = 3'd1,
      ALUOP_SUB   = 3'd2,
      ALUOP_OR    = 3'd3,
      ALUOP_FUNCT = 3'd4
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [2:0] SRCB_B     = 3'b000;
   localparam logic [2:0] SRCB_FOUR  = 3'b001;
   localparam logic [2:0] SRCB_IMM   = 3'b010;
   localparam logic [2:0] SRCB_IMMSH = 3'b011;
   localparam logic [2:0] SRCB_ZIMM  = 3'b100;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   function automatic logic funct_legal(input logic [5:0] f);
      return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
   endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: instruction fields and zero flag in, control strobes and debug state out.
// Latency/backpressure: wires only; master = controller, slave = datapath.
interface mc_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [2:0] alusrcb;
   logic [1:0] pcsrc;
   logic       pcen;
   logic [2:0] alucontrol;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op, funct, zero,
      output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, pcen, alucontrol, illegal, state
   );

   modport slave (
      output op, funct, zero,
      input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, pcen, alucontrol, illegal, state
   );
endinterface

// File: rtl/mc_aludec.sv
// mc_aludec: maps the FSM's aluop (and funct for R-type) to the ALU function code.
// Latency: combinational; no backpressure.
module mc_aludec
   import mc_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_AND;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_OR:  alucontrol = ALU_OR;
         ALUOP_FUNCT: begin
            case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_SUB:   alucontrol = ALU_SUB;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               default: alucontrol = ALU_AND;
            endcase
         end
         default: alucontrol = ALU_AND;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS Moore control FSM; MC_BNE_EN enables the bne path.
// Latency: 2-5 cycles per instruction, outputs from state (pcen also uses zero); no backpressure.
module mc_controller
   import mc_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   mc_if.master  bus
);

   state_t cur, nxt;
   aluop_t aluop;
   logic   pcwrite;
   logic   branch;
   logic [2:0] alucontrol;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur <= FETCH;
      else       cur <= nxt;
   end

   always_comb begin
      nxt          = FETCH;
      aluop        = ALUOP_NONE;
      pcwrite      = 1'b0;
      branch       = 1'b0;
      bus.iord     = 1'b0;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regdst   = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regwrite = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = SRCB_B;
      bus.pcsrc    = PCSRC_ALU;
      bus.illegal  = 1'b0;
      case (cur)
         FETCH: begin
            nxt         = DECODE;
            bus.irwrite = 1'b1;
            bus.alusrcb = SRCB_FOUR;
            pcwrite     = 1'b1;
            aluop       = ALUOP_ADD;
         end
         DECODE: begin
            bus.alusrcb = SRCB_IMMSH;
            aluop       = ALUOP_ADD;
            case (bus.op)
               OP_LW, OP_SW: nxt = MEMADR;
               OP_RTYPE: begin
                  if (funct_legal(bus.funct)) nxt = RTYPEEX;
                  else                        bus.illegal = 1'b1;
               end
               OP_BEQ:  nxt = BEQEX;
`ifdef MC_BNE_EN
               OP_BNE:  nxt = BNEEX;
`endif
               OP_ADDI: nxt = ADDIEX;
               OP_ORI:  nxt = ORIEX;
               OP_J:    nxt = JEX;
               default: bus.illegal = 1'b1;
            endcase
         end
         MEMADR, ADDIEX: begin
            nxt         = (cur == ADDIEX) ? IWB : ((bus.op == OP_LW) ? MEMRD : MEMWR);
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            aluop       = ALUOP_ADD;
         end
         MEMRD: begin
            nxt      = MEMWB;
            bus.iord = 1'b1;
         end
         MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
         end
         MEMWB: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
         end
         RTYPEEX: begin
            nxt         = RTYPEWB;
            bus.alusrca = 1'b1;
            aluop       = ALUOP_FUNCT;
         end
         RTYPEWB: begin
            bus.regdst   = 1'b1;
            bus.regwrite = 1'b1;
         end
         IWB: bus.regwrite = 1'b1;
         BEQEX: begin
            bus.alusrca = 1'b1;
            bus.pcsrc   = PCSRC_ALUOUT;
            aluop       = ALUOP_SUB;
            branch      = bus.zero;
         end
`ifdef MC_BNE_EN
         BNEEX: begin
            bus.alusrca = 1'b1;
            bus.pcsrc   = PCSRC_ALUOUT;
            aluop       = ALUOP_SUB;
            branch      = ~bus.zero;
         end
`endif
         ORIEX: begin
            nxt         = IWB;
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_ZIMM;
            aluop       = ALUOP_OR;
         end
         JEX: begin
            bus.pcsrc = PCSRC_JUMP;
            pcwrite   = 1'b1;
         end
         default: nxt = FETCH;
      endcase
   end

   mc_aludec u_aludec (
      .aluop      (aluop),
      .funct      (bus.funct),
      .alucontrol (alucontrol)
   );

   assign bus.alucontrol = alucontrol;
   assign bus.pcen       = pcwrite | branch;
   assign bus.state      = cur;

endmodule
